// File: rtl/sparse_outer_product_engine_pkg.sv
// Shared types and width helpers for the sparse outer-product engine.
package sparse_op_pkg;

  // Engine control states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACCUM = 3'd1,
    FLUSH = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

  // Accumulator width that holds n full-width products without overflow.
  function automatic int acc_w_f(input int n, input int dw);
    return 2 * dw + $clog2(n) + 1;
  endfunction

  // Width of a row/column index for an n-wide matrix (at least one bit).
  function automatic int idx_w_f(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sparse_outer_product_engine_mac_row.sv
// One row of C: N multipliers feeding a product register (stage 1)
// and N wrapping accumulators (stage 2).
module op_mac_row
  import sparse_op_pkg::*;
#(
  parameter int N      = 3,
  parameter int DATA_W = 8,
  parameter int ACC_W  = acc_w_f(3, 8),
  parameter bit SIGNED = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr_i,
  input  logic                ld_i,
  input  logic                prod_v_i,
  input  logic [DATA_W-1:0]   a_elem_i,
  input  logic [N*DATA_W-1:0] b_row_i,
  output logic [N*ACC_W-1:0]  acc_row_o
);

  localparam int PW = 2 * DATA_W;

  logic [PW-1:0]    a_ext_s;
  logic [PW-1:0]    b_ext_s [N];
  logic [PW-1:0]    mul_s   [N];
  logic [PW-1:0]    prod_q  [N];
  logic [ACC_W-1:0] prod_x_s [N];
  logic [ACC_W-1:0] acc_q   [N];
  logic [ACC_W-1:0] acc_d   [N];

  // Extend operands to product width so the low PW bits are the exact product.
  always_comb begin
    if (SIGNED) begin
      a_ext_s = {{DATA_W{a_elem_i[DATA_W-1]}}, a_elem_i};
    end else begin
      a_ext_s = {{DATA_W{1'b0}}, a_elem_i};
    end
    for (int j = 0; j < N; j++) begin
      if (SIGNED) begin
        b_ext_s[j] = {{DATA_W{b_row_i[j*DATA_W+DATA_W-1]}}, b_row_i[j*DATA_W +: DATA_W]};
      end else begin
        b_ext_s[j] = {{DATA_W{1'b0}}, b_row_i[j*DATA_W +: DATA_W]};
      end
      mul_s[j] = a_ext_s * b_ext_s[j];
    end
  end

  // Widen stored products to accumulator width and form the next sums.
  always_comb begin
    for (int j = 0; j < N; j++) begin
      if (SIGNED) begin
        prod_x_s[j] = {{(ACC_W-PW){prod_q[j][PW-1]}}, prod_q[j]};
      end else begin
        prod_x_s[j] = {{(ACC_W-PW){1'b0}}, prod_q[j]};
      end
      if (clr_i) begin
        acc_d[j] = '0;
      end else if (prod_v_i) begin
        acc_d[j] = acc_q[j] + prod_x_s[j];
      end else begin
        acc_d[j] = acc_q[j];
      end
    end
  end

  // Product and accumulator registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int j = 0; j < N; j++) begin
        prod_q[j] <= '0;
        acc_q[j]  <= '0;
      end
    end else begin
      for (int j = 0; j < N; j++) begin
        if (ld_i) begin
          prod_q[j] <= mul_s[j];
        end
        acc_q[j] <= acc_d[j];
      end
    end
  end

  for (genvar j = 0; j < N; j++) begin : g_out
    assign acc_row_o[j*ACC_W +: ACC_W] = acc_q[j];
  end

endmodule

// File: rtl/sparse_outer_product_engine.sv
// NxN matrix multiply by outer-product accumulation: takes one A column and
// one B row per beat, accumulates N*N products, then streams C row-major.
module sparse_outer_product_engine
  import sparse_op_pkg::*;
#(
  parameter int N         = 3,
  parameter int DATA_W    = 8,
  parameter int ACC_W     = acc_w_f(N, DATA_W),
  parameter bit SIGNED    = 1'b0,
  parameter bit SKIP_ZERO = 1'b1,
  localparam int IDX_W    = idx_w_f(N),
  localparam int CNT_W    = $clog2(N + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N*DATA_W-1:0] a_col,
  input  logic [N*DATA_W-1:0] b_row,
  output logic                c_valid,
  input  logic                c_ready,
  output logic [ACC_W-1:0]    c_data,
  output logic [IDX_W-1:0]    c_row,
  output logic [IDX_W-1:0]    c_col,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    skip_count
);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N - 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] beat_q, beat_d;
  logic [CNT_W-1:0] skip_q, skip_d;
  logic [IDX_W-1:0] row_q, row_d;
  logic [IDX_W-1:0] col_q, col_d;
  logic             prod_v_q, prod_v_d;
  logic             in_ready_q, c_valid_q, busy_q, done_q;

  logic accept_s, zero_s, skip_s, clr_s, c_fire_s, last_elem_s;

  logic [N*ACC_W-1:0] acc_row_s [N];
  logic [ACC_W-1:0]   acc_s     [N][N];

  assign accept_s    = in_valid && (state_q == ACCUM);
  assign zero_s      = (a_col == '0) || (b_row == '0);
  assign skip_s      = SKIP_ZERO && zero_s;
  assign clr_s       = (state_q == IDLE) && start;
  assign c_fire_s    = (state_q == DRAIN) && c_ready;
  assign last_elem_s = (row_q == LAST_IDX) && (col_q == LAST_IDX);

  // Next-state logic for the run sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = ACCUM;
        else       state_d = IDLE;
      end
      ACCUM: begin
        if (accept_s && (beat_q == LAST_BEAT)) state_d = FLUSH;
        else                                   state_d = ACCUM;
      end
      FLUSH: state_d = DRAIN;
      DRAIN: begin
        if (c_fire_s && last_elem_s) state_d = DONE;
        else                         state_d = DRAIN;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Beat/skip counters, product-valid flag and drain index walk.
  always_comb begin
    beat_d   = beat_q;
    skip_d   = skip_q;
    prod_v_d = 1'b0;
    row_d    = row_q;
    col_d    = col_q;
    if (clr_s) begin
      beat_d = '0;
      skip_d = '0;
    end else if (accept_s) begin
      beat_d   = beat_q + CNT_W'(1);
      prod_v_d = !skip_s;
      if (skip_s) skip_d = skip_q + CNT_W'(1);
      else        skip_d = skip_q;
    end else begin
      beat_d = beat_q;
      skip_d = skip_q;
    end
    if (c_fire_s) begin
      if (col_q == LAST_IDX) begin
        col_d = '0;
        if (row_q == LAST_IDX) row_d = '0;
        else                   row_d = row_q + IDX_W'(1);
      end else begin
        col_d = col_q + IDX_W'(1);
      end
    end else begin
      row_d = row_q;
      col_d = col_q;
    end
  end

  // Control registers; status flags are registered from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      skip_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      prod_v_q   <= 1'b0;
      in_ready_q <= 1'b0;
      c_valid_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      skip_q     <= skip_d;
      row_q      <= row_d;
      col_q      <= col_d;
      prod_v_q   <= prod_v_d;
      in_ready_q <= (state_d == ACCUM);
      c_valid_q  <= (state_d == DRAIN);
      busy_q     <= (state_d != IDLE);
      done_q     <= (state_d == DONE);
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    op_mac_row #(
      .N      (N),
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W),
      .SIGNED (SIGNED)
    ) u_row (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr_i     (clr_s),
      .ld_i      (accept_s),
      .prod_v_i  (prod_v_q),
      .a_elem_i  (a_col[i*DATA_W +: DATA_W]),
      .b_row_i   (b_row),
      .acc_row_o (acc_row_s[i])
    );
    for (genvar j = 0; j < N; j++) begin : g_col
      assign acc_s[i][j] = acc_row_s[i][j*ACC_W +: ACC_W];
    end
  end

  assign in_ready   = in_ready_q;
  assign c_valid    = c_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign skip_count = skip_q;
  assign c_row      = row_q;
  assign c_col      = col_q;
  assign c_data     = acc_s[row_q][col_q];

endmodule

// File: tb/tb_sparse_outer_product_engine.sv
// Directed bench: unsigned and signed engines share stimulus; each test
// checks the instance it targets against hand-computed C matrices.
module tb_sparse_outer_product_engine;

  logic        clk = 1'b0;
  logic        rst_n, start, in_valid, c_ready;
  logic [23:0] a_col, b_row;

  logic        u_in_ready, u_c_valid, u_busy, u_done;
  logic [18:0] u_c_data;
  logic [1:0]  u_c_row, u_c_col, u_skip;
  logic        s_in_ready, s_c_valid, s_busy, s_done;
  logic [18:0] s_c_data;
  logic [1:0]  s_c_row, s_c_col, s_skip;

  bit          use_s = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_c [9];

  always #5 clk = ~clk;

  sparse_outer_product_engine #(.N(3), .DATA_W(8), .SIGNED(1'b0), .SKIP_ZERO(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(u_in_ready),
    .a_col(a_col), .b_row(b_row), .c_valid(u_c_valid), .c_ready(c_ready), .c_data(u_c_data),
    .c_row(u_c_row), .c_col(u_c_col), .busy(u_busy), .done(u_done), .skip_count(u_skip));

  sparse_outer_product_engine #(.N(3), .DATA_W(8), .SIGNED(1'b1), .SKIP_ZERO(1'b1)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(s_in_ready),
    .a_col(a_col), .b_row(b_row), .c_valid(s_c_valid), .c_ready(c_ready), .c_data(s_c_data),
    .c_row(s_c_row), .c_col(s_c_col), .busy(s_busy), .done(s_done), .skip_count(s_skip));

  wire        o_in_ready = use_s ? s_in_ready : u_in_ready;
  wire        o_c_valid  = use_s ? s_c_valid  : u_c_valid;
  wire        o_busy     = use_s ? s_busy     : u_busy;
  wire        o_done     = use_s ? s_done     : u_done;
  wire [18:0] o_c_data   = use_s ? s_c_data   : u_c_data;
  wire [1:0]  o_c_row    = use_s ? s_c_row    : u_c_row;
  wire [1:0]  o_c_col    = use_s ? s_c_col    : u_c_col;
  wire [1:0]  o_skip     = use_s ? s_skip     : u_skip;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Present one beat; then hold in_valid low for gap cycles, optionally pulsing start.
  task automatic beat(input logic [23:0] a, input logic [23:0] b, input int gap, input bit poke);
    @(negedge clk);
    chk("in_ready", 32'(o_in_ready), 32'd1);
    in_valid = 1'b1;
    a_col    = a;
    b_row    = b;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      in_valid = 1'b0;
      start    = poke && (g == 0);
    end
    start = 1'b0;
  endtask

  // Consume the nine outputs against exp_c, then check the done pulse.
  task automatic drain(input bit stall, input bit poke);
    int          idx   = 0;
    int          cyc   = 0;
    int          first = -1;
    logic [3:0]  pat   = 4'b1001;
    while (idx < 9 && cyc < 200) begin
      @(negedge clk);
      start   = poke && (cyc == 2);
      c_ready = stall ? pat[cyc[1:0]] : 1'b1;
      if (o_c_valid) begin
        if (first < 0) first = cyc;
        chk("c_data", 32'(o_c_data), exp_c[idx]);
        chk("c_row", 32'(o_c_row), 32'(idx / 3));
        chk("c_col", 32'(o_c_col), 32'(idx % 3));
        if (c_ready) idx++;
      end
      cyc++;
    end
    if (idx < 9) chk("drain_timeout", 32'(idx), 32'd9);
    chk("first_c_valid", 32'(first), 32'd0);
    @(negedge clk);
    chk("done_pulse", 32'(o_done), 32'd1);
    chk("c_valid_in_done", 32'(o_c_valid), 32'd0);
    chk("busy_in_done", 32'(o_busy), 32'd1);
    start   = 1'b1;
    c_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("done_cleared", 32'(o_done), 32'd0);
    chk("idle_after_done", 32'(o_busy), 32'd0);
    @(negedge clk);
    chk("start_in_done_ignored", 32'(o_busy), 32'd0);
  endtask

  task automatic run(input logic [23:0] a0, input logic [23:0] a1, input logic [23:0] a2,
                     input logic [23:0] b0, input logic [23:0] b1, input logic [23:0] b2,
                     input int gap, input bit poke_acc, input bit stall, input bit poke_drain,
                     input logic [31:0] exp_skip);
    do_start();
    beat(a0, b0, gap, poke_acc);
    beat(a1, b1, gap, 1'b0);
    beat(a2, b2, 0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("c_valid_in_flush", 32'(o_c_valid), 32'd0);
    chk("busy_in_flush", 32'(o_busy), 32'd1);
    drain(stall, poke_drain);
    chk("skip_count", 32'(o_skip), exp_skip);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; c_ready = 1'b1;
    a_col = 24'h0; b_row = 24'h0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_in_ready", 32'(o_in_ready), 32'd0);
    chk("rst_c_valid", 32'(o_c_valid), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_c_data", 32'(o_c_data), 32'd0);
    chk("rst_c_row", 32'(o_c_row), 32'd0);
    chk("rst_c_col", 32'(o_c_col), 32'd0);
    chk("rst_skip", 32'(o_skip), 32'd0);
    rst_n = 1'b1;

    // Test 1: A * I = A.
    for (int i = 0; i < 9; i++) exp_c[i] = 32'(i + 1);
    run(24'h070401, 24'h080502, 24'h090603, 24'h000001, 24'h000100, 24'h010000,
        0, 1'b0, 1'b0, 1'b0, 32'd0);

    // Test 2: all-255 operands reach 3*255*255 without wrapping.
    for (int i = 0; i < 9; i++) exp_c[i] = 32'd195075;
    run(24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF,
        0, 1'b0, 1'b0, 1'b0, 32'd0);

    // Test 3: A column 1 zero is skipped; rows 1+9, 4+18, 7+27.
    for (int i = 0; i < 3; i++) begin
      exp_c[i] = 32'd10; exp_c[3+i] = 32'd22; exp_c[6+i] = 32'd34;
    end
    run(24'h070401, 24'h000000, 24'h090603, 24'h010101, 24'h020202, 24'h030303,
        0, 1'b0, 1'b0, 1'b0, 32'd1);

    // Test 4: signed engine, (-1)*2 summed three times = -6.
    use_s = 1'b1;
    for (int i = 0; i < 9; i++) exp_c[i] = 32'h7FFFA;
    run(24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'h020202, 24'h020202, 24'h020202,
        0, 1'b0, 1'b0, 1'b0, 32'd0);
    use_s = 1'b0;

    // Test 5: gapped beats, start pokes in ACCUM and DRAIN, c_ready 1,0,0,1.
    for (int i = 0; i < 9; i++) exp_c[i] = 32'(i + 1);
    run(24'h070401, 24'h080502, 24'h090603, 24'h000001, 24'h000100, 24'h010000,
        2, 1'b1, 1'b1, 1'b1, 32'd0);

    // Test 6: reset after two beats, then a clean test-1 run.
    do_start();
    beat(24'hFFFFFF, 24'hFFFFFF, 0, 1'b0);
    beat(24'hFFFFFF, 24'hFFFFFF, 0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_busy", 32'(o_busy), 32'd0);
    chk("midrst_in_ready", 32'(o_in_ready), 32'd0);
    chk("midrst_c_data", 32'(o_c_data), 32'd0);
    chk("midrst_skip", 32'(o_skip), 32'd0);
    run(24'h070401, 24'h080502, 24'h090603, 24'h000001, 24'h000100, 24'h010000,
        0, 1'b0, 1'b0, 1'b0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
